// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: the pipeline owns the write port, long-latency
// results bypass when the port is free or wait in a 2-entry FIFO with WAW kill.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_data_i,
    input  logic        lu_valid_i,
    input  logic [4:0]  lu_rd_i,
    input  logic [31:0] lu_data_i,
    output logic        lu_ready_o,
    input  logic [4:0]  chk_rs1_i,
    input  logic [4:0]  chk_rs2_i,
    output logic        pend_hit_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_data_o,
    output logic        stall_req_o
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  count;
    logic [4:0]  ent_rd   [2];
    logic [31:0] ent_data [2];
    logic [3:0]  wait_cnt;
    logic        stall_q;

    logic        pipe_wr, lu_acc, drain, bypass, enq;
    logic        keep0, keep1, head_gone;
    logic [1:0]  count_nxt;
    logic [4:0]  rd_nxt   [2];
    logic [31:0] data_nxt [2];
    logic [3:0]  wait_nxt;

    assign lu_ready_o  = (count != 2'd2);
    assign stall_req_o = stall_q;

    always_comb begin
        pipe_wr = pipe_we_i && (pipe_rd_i != 5'd0);
        lu_acc  = lu_valid_i && lu_ready_o;
        drain   = !pipe_wr && (count != 2'd0);
        bypass  = !pipe_wr && (count == 2'd0) && lu_acc && (lu_rd_i != 5'd0);
        enq     = lu_acc && (lu_rd_i != 5'd0) && !bypass &&
                  !(pipe_wr && (lu_rd_i == pipe_rd_i));

        // A pipe write to the same rd makes any older buffered value stale.
        keep0 = (count != 2'd0) && !drain && !(pipe_wr && (ent_rd[0] == pipe_rd_i));
        keep1 = (count == 2'd2) && !(pipe_wr && (ent_rd[1] == pipe_rd_i));
        head_gone = (count != 2'd0) && !keep0;

        rd_nxt[0]   = ent_rd[0];
        rd_nxt[1]   = ent_rd[1];
        data_nxt[0] = ent_data[0];
        data_nxt[1] = ent_data[1];
        count_nxt   = 2'd0;
        case ({keep0, keep1})
            2'b11: count_nxt = 2'd2;
            2'b10: count_nxt = 2'd1;
            2'b01: begin
                rd_nxt[0]   = ent_rd[1];
                data_nxt[0] = ent_data[1];
                count_nxt   = 2'd1;
            end
            default: count_nxt = 2'd0;
        endcase
        if (enq) begin
            if (count_nxt == 2'd0) begin
                rd_nxt[0]   = lu_rd_i;
                data_nxt[0] = lu_data_i;
            end else begin
                rd_nxt[1]   = lu_rd_i;
                data_nxt[1] = lu_data_i;
            end
            count_nxt = count_nxt + 2'd1;
        end

        if ((count == 2'd0) || head_gone)
            wait_nxt = 4'd0;
        else if (wait_cnt != 4'd15)
            wait_nxt = wait_cnt + 4'd1;
        else
            wait_nxt = wait_cnt;
    end

    always_comb begin
        rf_we_o   = 1'b0;
        rf_rd_o   = 5'd0;
        rf_data_o = 32'd0;
        if (pipe_wr) begin
            rf_we_o   = 1'b1;
            rf_rd_o   = pipe_rd_i;
            rf_data_o = pipe_data_i;
        end else if (count != 2'd0) begin
            rf_we_o   = 1'b1;
            rf_rd_o   = ent_rd[0];
            rf_data_o = ent_data[0];
        end else if (bypass) begin
            rf_we_o   = 1'b1;
            rf_rd_o   = lu_rd_i;
            rf_data_o = lu_data_i;
        end
    end

    always_comb begin
        pend_hit_o = 1'b0;
        if ((count != 2'd0) && (ent_rd[0] != 5'd0) &&
            ((ent_rd[0] == chk_rs1_i) || (ent_rd[0] == chk_rs2_i)))
            pend_hit_o = 1'b1;
        if ((count == 2'd2) && (ent_rd[1] != 5'd0) &&
            ((ent_rd[1] == chk_rs1_i) || (ent_rd[1] == chk_rs2_i)))
            pend_hit_o = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= 2'd0;
            wait_cnt <= 4'd0;
            stall_q  <= 1'b0;
        end else begin
            count    <= count_nxt;
            wait_cnt <= wait_nxt;
            stall_q  <= (wait_nxt >= LIMIT);
        end
    end

    // Entry payload carries no reset; validity is defined solely by count.
    always_ff @(posedge clk) begin
        ent_rd[0]   <= rd_nxt[0];
        ent_rd[1]   <= rd_nxt[1];
        ent_data[0] <= data_nxt[0];
        ent_data[1] <= data_nxt[1];
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_rf_wb_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        lu_valid_i;
    logic [4:0]  lu_rd_i;
    logic [31:0] lu_data_i;
    logic        lu_ready_o;
    logic [4:0]  chk_rs1_i;
    logic [4:0]  chk_rs2_i;
    logic        pend_hit_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_data_o;
    logic        stall_req_o;

    int n_checks = 0;
    int n_pass   = 0;

    rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .pipe_we_i(pipe_we_i), .pipe_rd_i(pipe_rd_i), .pipe_data_i(pipe_data_i),
        .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_data_i(lu_data_i),
        .lu_ready_o(lu_ready_o),
        .chk_rs1_i(chk_rs1_i), .chk_rs2_i(chk_rs2_i), .pend_hit_o(pend_hit_o),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
        .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    // Reference model: pending results as an ordered list plus head wait age.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];
    int   mwait;
    bit   mstall;
    logic        exp_we, exp_ready, exp_hit, exp_stall;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    function automatic void model_clear();
        mq.delete();
        mwait  = 0;
        mstall = 0;
    endfunction

    function automatic void model_expect();
        bit pw;
        bit acc;
        pw  = pipe_we_i && (pipe_rd_i != 0);
        acc = lu_valid_i && (mq.size() < 2);
        exp_ready = (mq.size() < 2);
        exp_stall = mstall;
        exp_we = 0; exp_rd = 0; exp_data = 0;
        if (pw) begin
            exp_we = 1; exp_rd = pipe_rd_i; exp_data = pipe_data_i;
        end else if (mq.size() > 0) begin
            exp_we = 1; exp_rd = mq[0].rd; exp_data = mq[0].data;
        end else if (acc && lu_rd_i != 0) begin
            exp_we = 1; exp_rd = lu_rd_i; exp_data = lu_data_i;
        end
        exp_hit = 0;
        foreach (mq[i]) begin
            if (chk_rs1_i != 0 && mq[i].rd == chk_rs1_i) exp_hit = 1;
            if (chk_rs2_i != 0 && mq[i].rd == chk_rs2_i) exp_hit = 1;
        end
    endfunction

    function automatic void model_edge();
        bit   pw;
        bit   acc;
        bit   byp;
        bit   head_changed;
        int   old;
        ent_t e;
        pw  = pipe_we_i && (pipe_rd_i != 0);
        acc = lu_valid_i && (mq.size() < 2);
        old = mq.size();
        byp = !pw && old == 0 && acc && lu_rd_i != 0;
        head_changed = 0;
        if (!pw && old > 0) begin
            void'(mq.pop_front());
            head_changed = 1;
        end
        if (pw) begin
            if (old > 0 && mq[0].rd == pipe_rd_i) head_changed = 1;
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].rd == pipe_rd_i) mq.delete(i);
        end
        if (acc && lu_rd_i != 0 && !byp && !(pw && lu_rd_i == pipe_rd_i)) begin
            e.rd = lu_rd_i;
            e.data = lu_data_i;
            mq.push_back(e);
        end
        if (old == 0 || head_changed) mwait = 0;
        else if (mwait < 15) mwait++;
        mstall = (mwait >= LIMIT);
    endfunction

    task automatic drive(input bit pwe, input int prd, input int pdata,
                         input bit lv, input int lrd, input int ldata);
        pipe_we_i   = pwe;
        pipe_rd_i   = 5'(prd);
        pipe_data_i = 32'(pdata);
        lu_valid_i  = lv;
        lu_rd_i     = 5'(lrd);
        lu_data_i   = 32'(ldata);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk_rs1_i = 0;
        chk_rs2_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        chk_rs1_i = 5;
        sample();
        n_checks++; if (lu_ready_o !== 1'b1) $display("FAIL reset_ready: got %0b want 1", lu_ready_o); else n_pass++;
        n_checks++; if (pend_hit_o !== 1'b0) $display("FAIL reset_hit: got %0b want 0", pend_hit_o); else n_pass++;
        n_checks++; if (rf_we_o !== 1'b0) $display("FAIL reset_we: got %0b want 0", rf_we_o); else n_pass++;
        n_checks++; if (stall_req_o !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall_req_o); else n_pass++;
        n_checks++; if (rf_rd_o !== 5'd0 || rf_data_o !== 32'd0) $display("FAIL reset_rf: got rd=%0d data=%h want 0/0", rf_rd_o, rf_data_o); else n_pass++;
        tick();
        chk_rs1_i = 0;
    endtask

    task automatic test_bypass();
        drive(0, 0, 0, 1, 5, 32'hA5A5A5A5);
        sample();
        n_checks++; if (rf_we_o !== 1'b1) $display("FAIL bypass_we: got %0b want 1", rf_we_o); else n_pass++;
        n_checks++; if (rf_rd_o !== 5'd5) $display("FAIL bypass_rd: got %0d want 5", rf_rd_o); else n_pass++;
        n_checks++; if (rf_data_o !== 32'hA5A5A5A5) $display("FAIL bypass_data: got %h want a5a5a5a5", rf_data_o); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk_rs1_i = 5;
        sample();
        n_checks++; if (rf_we_o !== 1'b0) $display("FAIL bypass_after_we: got %0b want 0", rf_we_o); else n_pass++;
        n_checks++; if (pend_hit_o !== 1'b0) $display("FAIL bypass_not_buffered: got %0b want 0", pend_hit_o); else n_pass++;
        tick();
    endtask

    task automatic test_collision();
        drive(1, 3, 32'h11, 1, 7, 32'h22);
        chk_rs1_i = 7;
        sample();
        n_checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd3 || rf_data_o !== 32'h11) $display("FAIL coll_pipe: got we=%0b rd=%0d data=%h want 1/3/11", rf_we_o, rf_rd_o, rf_data_o); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        n_checks++; if (pend_hit_o !== 1'b1) $display("FAIL coll_hit: got %0b want 1", pend_hit_o); else n_pass++;
        n_checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd7 || rf_data_o !== 32'h22) $display("FAIL coll_drain: got we=%0b rd=%0d data=%h want 1/7/22", rf_we_o, rf_rd_o, rf_data_o); else n_pass++;
        tick();
        sample();
        n_checks++; if (rf_we_o !== 1'b0 || pend_hit_o !== 1'b0) $display("FAIL coll_idle: got we=%0b hit=%0b want 0/0", rf_we_o, pend_hit_o); else n_pass++;
        tick();
        chk_rs1_i = 0;
    endtask

    task automatic test_full();
        drive(1, 1, 100, 1, 10, 32'hA);
        sample();
        n_checks++; if (lu_ready_o !== 1'b1) $display("FAIL full_ready0: got %0b want 1", lu_ready_o); else n_pass++;
        tick();
        drive(1, 2, 200, 1, 11, 32'hB);
        sample();
        n_checks++; if (lu_ready_o !== 1'b1 || rf_rd_o !== 5'd2) $display("FAIL full_ready1: got ready=%0b rd=%0d want 1/2", lu_ready_o, rf_rd_o); else n_pass++;
        tick();
        drive(1, 3, 300, 1, 12, 32'hC);
        sample();
        n_checks++; if (lu_ready_o !== 1'b0) $display("FAIL full_ready2: got %0b want 0", lu_ready_o); else n_pass++;
        tick();
        sample();
        n_checks++; if (lu_ready_o !== 1'b0 || rf_rd_o !== 5'd3) $display("FAIL full_hold: got ready=%0b rd=%0d want 0/3", lu_ready_o, rf_rd_o); else n_pass++;
        tick();
        drive(0, 0, 0, 1, 12, 32'hC);
        sample();
        n_checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd10 || rf_data_o !== 32'hA) $display("FAIL full_drain0: got we=%0b rd=%0d data=%h want 1/10/a", rf_we_o, rf_rd_o, rf_data_o); else n_pass++;
        n_checks++; if (lu_ready_o !== 1'b0) $display("FAIL full_ready3: got %0b want 0", lu_ready_o); else n_pass++;
        tick();
        sample();
        n_checks++; if (rf_rd_o !== 5'd11 || rf_data_o !== 32'hB || lu_ready_o !== 1'b1) $display("FAIL full_drain1: got rd=%0d data=%h ready=%0b want 11/b/1", rf_rd_o, rf_data_o, lu_ready_o); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        n_checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd12 || rf_data_o !== 32'hC) $display("FAIL full_drain2: got we=%0b rd=%0d data=%h want 1/12/c", rf_we_o, rf_rd_o, rf_data_o); else n_pass++;
        tick();
        sample();
        n_checks++; if (rf_we_o !== 1'b0) $display("FAIL full_empty: got %0b want 0", rf_we_o); else n_pass++;
        tick();
    endtask

    task automatic test_starve();
        drive(1, 1, 32'h55, 1, 9, 32'h99);
        chk_rs2_i = 9;
        sample();
        tick();
        drive(1, 1, 32'h55, 0, 0, 0);
        for (int k = 1; k <= LIMIT; k++) begin
            sample();
            n_checks++; if (stall_req_o !== 1'b0) $display("FAIL starve_early%0d: got %0b want 0", k, stall_req_o); else n_pass++;
            tick();
        end
        sample();
        n_checks++; if (stall_req_o !== 1'b1) $display("FAIL starve_assert: got %0b want 1", stall_req_o); else n_pass++;
        n_checks++; if (pend_hit_o !== 1'b1) $display("FAIL starve_hit: got %0b want 1", pend_hit_o); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        n_checks++; if (rf_we_o !== 1'b1 || rf_rd_o !== 5'd9 || rf_data_o !== 32'h99) $display("FAIL starve_drain: got we=%0b rd=%0d data=%h want 1/9/99", rf_we_o, rf_rd_o, rf_data_o); else n_pass++;
        n_checks++; if (stall_req_o !== 1'b1) $display("FAIL starve_hold: got %0b want 1", stall_req_o); else n_pass++;
        tick();
        sample();
        n_checks++; if (stall_req_o !== 1'b0 || rf_we_o !== 1'b0) $display("FAIL starve_clear: got stall=%0b we=%0b want 0/0", stall_req_o, rf_we_o); else n_pass++;
        tick();
        chk_rs2_i = 0;
    endtask

    task automatic test_waw();
        drive(1, 1, 32'h10, 1, 4, 32'h1);
        sample();
        tick();
        drive(1, 4, 32'h2, 0, 0, 0);
        chk_rs1_i = 4;
        sample();
        n_checks++; if (pend_hit_o !== 1'b1) $display("FAIL waw_hit_before: got %0b want 1", pend_hit_o); else n_pass++;
        n_checks++; if (rf_rd_o !== 5'd4 || rf_data_o !== 32'h2) $display("FAIL waw_pipe: got rd=%0d data=%h want 4/2", rf_rd_o, rf_data_o); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        n_checks++; if (rf_we_o !== 1'b0) $display("FAIL waw_no_stale: got we=%0b rd=%0d data=%h want we=0", rf_we_o, rf_rd_o, rf_data_o); else n_pass++;
        n_checks++; if (pend_hit_o !== 1'b0) $display("FAIL waw_hit_after: got %0b want 0", pend_hit_o); else n_pass++;
        tick();
        chk_rs1_i = 0;
    endtask

    task automatic test_reset_midop();
        drive(1, 1, 1, 1, 20, 32'hD);
        tick();
        drive(1, 2, 2, 1, 21, 32'hE);
        tick();
        drive(1, 3, 3, 0, 0, 0);
        chk_rs1_i = 20;
        sample();
        n_checks++; if (lu_ready_o !== 1'b0 || pend_hit_o !== 1'b1) $display("FAIL midop_full: got ready=%0b hit=%0b want 0/1", lu_ready_o, pend_hit_o); else n_pass++;
        drive(0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        #1;
        n_checks++; if (lu_ready_o !== 1'b1) $display("FAIL midop_ready: got %0b want 1", lu_ready_o); else n_pass++;
        n_checks++; if (stall_req_o !== 1'b0) $display("FAIL midop_stall: got %0b want 0", stall_req_o); else n_pass++;
        n_checks++; if (pend_hit_o !== 1'b0 || rf_we_o !== 1'b0) $display("FAIL midop_async: got hit=%0b we=%0b want 0/0", pend_hit_o, rf_we_o); else n_pass++;
        tick();
        tick();
        @(negedge clk);
        resetn = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            sample();
            n_checks++; if (rf_we_o !== 1'b0) $display("FAIL midop_no_write%0d: got we=%0b rd=%0d want 0", k, rf_we_o, rf_rd_o); else n_pass++;
            tick();
        end
        chk_rs1_i = 0;
    endtask

    task automatic test_random();
        int pct;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pct = ((i / 50) % 2 == 1) ? 90 : 40;
            drive($urandom_range(99) < pct, $urandom_range(7), $urandom,
                  $urandom_range(99) < 60, $urandom_range(7), $urandom);
            chk_rs1_i = 5'($urandom_range(7));
            chk_rs2_i = 5'($urandom_range(7));
            sample();
            model_expect();
            n_checks++; if (rf_we_o !== exp_we) $display("FAIL rnd_we c%0d: got %0b want %0b", i, rf_we_o, exp_we); else n_pass++;
            n_checks++; if (exp_we && (rf_rd_o !== exp_rd || rf_data_o !== exp_data)) $display("FAIL rnd_rf c%0d: got rd=%0d data=%h want rd=%0d data=%h", i, rf_rd_o, rf_data_o, exp_rd, exp_data); else n_pass++;
            n_checks++; if (lu_ready_o !== exp_ready) $display("FAIL rnd_ready c%0d: got %0b want %0b", i, lu_ready_o, exp_ready); else n_pass++;
            n_checks++; if (pend_hit_o !== exp_hit) $display("FAIL rnd_hit c%0d: got %0b want %0b", i, pend_hit_o, exp_hit); else n_pass++;
            n_checks++; if (stall_req_o !== exp_stall) $display("FAIL rnd_stall c%0d: got %0b want %0b", i, stall_req_o, exp_stall); else n_pass++;
            @(posedge clk);
            model_edge();
            #1;
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk_rs1_i = 0;
        chk_rs2_i = 0;
        test_reset();
        test_bypass();
        test_collision();
        test_full();
        test_starve();
        test_waw();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning cycles a buffered entry waits before stall_req_o asserts (legal range 1..15).
REQ-002 SHALL have ports, clock and reset first:
  clk  input  1  rising-edge clock
  resetn  input  1  reset; one clock, reset asynchronous and active-low
  pipe_we_i  input  1  pipeline writeback enable from WB stage
  pipe_rd_i  input  5  pipeline writeback register index
  pipe_data_i  input  32  pipeline writeback data
  lu_valid_i  input  1  long-latency unit result valid
  lu_rd_i  input  5  long-latency unit destination index
  lu_data_i  input  32  long-latency unit result data
  lu_ready_o  output  1  arbiter can accept an lu result this cycle
  chk_rs1_i  input  5  hazard query index 1
  chk_rs2_i  input  5  hazard query index 2
  pend_hit_o  output  1  a query index matches a buffered entry
  rf_we_o  output  1  register file write enable
  rf_rd_o  output  5  register file write index
  rf_data_o  output  32  register file write data
  stall_req_o  output  1  request pipeline bubble to drain buffer

Function
REQ-003 SHALL hold a 2-entry FIFO of {rd, data} for lu results; count 0..2.
REQ-004 SHALL treat the pipeline as owning the write slot when pipe_we_i=1 and pipe_rd_i!=0 ("pipe write"); the slot is free otherwise.
REQ-005 SHALL drive rf_* combinationally: pipe write -> pipeline fields; else FIFO non-empty -> head entry (drain); else accepted lu with rd!=0 -> lu fields (bypass, zero latency); else rf_we_o=0, rf_rd_o=0, rf_data_o=0.
REQ-006 SHALL drive lu_ready_o = (count<2); an lu result is accepted when lu_valid_i & lu_ready_o.
REQ-007 SHALL enqueue an accepted lu result at the clock edge unless bypassed, its rd=0, or its rd equals a concurrent pipe write's rd; the last two are discarded.
REQ-008 SHALL pop the head at the clock edge on a drain; a simultaneous drain and enqueue leaves count unchanged, the new entry appended behind the remaining one.
REQ-009 SHALL on a pipe write invalidate (WAW kill) every buffered entry whose rd equals pipe_rd_i at that edge, compacting the FIFO in order.
REQ-010 SHALL never write a buffered entry after a newer pipe write to the same rd.
REQ-011 SHALL maintain a 4-bit wait counter: cleared when FIFO empty or on drain/kill of the head; incremented (saturating at 15) each cycle the head is present and not drained.
REQ-012 SHALL drive stall_req_o = 1 from a register when wait counter >= STARVE_LIMIT, clearing the cycle after the head drains.
REQ-013 SHALL drive pend_hit_o = 1 when any valid FIFO entry rd (nonzero) equals chk_rs1_i or chk_rs2_i; query index 0 never hits.
REQ-014 SHALL not stall or back-pressure the pipeline by any means other than stall_req_o.

Reset
REQ-015 SHALL on resetn=0, asynchronously: FIFO count 0, entries invalid, wait counter 0, stall_req_o=0; hence lu_ready_o=1, pend_hit_o=0, rf_we_o=0 absent pipe write.
REQ-016 SHALL discard buffered entries on reset mid-operation; no RF write of discarded data after resetn rises.

Verification
REQ-017 Bypass: FIFO empty, pipe_we_i=0, lu rd=5 data=0xA5A5A5A5 -> same cycle rf_we_o=1, rf_rd_o=5, rf_data_o=0xA5A5A5A5; count stays 0.
REQ-018 Collision: pipe write rd=3 data=0x11 and lu rd=7 data=0x22 same cycle -> rf writes rd=3 0x11; next free cycle rf writes rd=7 0x22; pend_hit_o=1 for chk_rs1_i=7 in between.
REQ-019 Full: two lu results buffered under continuous pipe writes -> lu_ready_o=0; third lu_valid_i held until a free cycle drains one, then accepted.
REQ-020 Starvation STARVE_LIMIT=4: entry rd=9 buffered, pipe writes every cycle -> stall_req_o=1 after 4 waiting cycles; pipe_we_i=0 -> rd=9 written, stall_req_o=0 next cycle.
REQ-021 WAW kill: buffered rd=4 data=0x1, pipe write rd=4 data=0x2 -> entry dropped; RF sees only 0x2 for rd=4; pend_hit_o for rs=4 falls to 0.
REQ-022 Reset mid-op: count=2, resetn pulsed low -> count 0, lu_ready_o=1, stall_req_o=0 immediately; no buffered write ever appears.
